// File: rtl/io_pkg.sv
// Shared types and default constants for the CPU input-port blocks.
package io_pkg;

    typedef enum logic {
        STABLE   = 1'b0,
        SETTLING = 1'b1
    } deb_state_t;

    localparam int unsigned SW_WORD_W          = 8;
    localparam int unsigned SW_SYNC_STAGES     = 2;
    localparam int unsigned SW_DEBOUNCE_CYCLES = 4;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchroniser for asynchronous inputs; q is the last stage.
module sync_chain #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clock,
    input  logic             n_reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stages [DEPTH];

    // Plain flop-to-flop chain, no logic between stages.
    always_ff @(posedge clock) begin
        if (!n_reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= d;
            for (int i = 1; i < int'(DEPTH); i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign q = stages[DEPTH-1];

endmodule

// File: rtl/switch_input_port.sv
// Synchronised, debounced reader for the switch bus with CPU read handshake flags.
module switch_input_port
    import io_pkg::*;
#(
    parameter int unsigned WORD_W          = SW_WORD_W,
    parameter int unsigned SYNC_STAGES     = SW_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES
) (
    input  logic              clock,
    input  logic              n_reset,
    input  logic [WORD_W-1:0] sw,
    input  logic              rd,
    output logic [WORD_W-1:0] data,
    output logic              new_data,
    output logic              overrun
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] COUNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    deb_state_t        state, state_nxt;
    logic [WORD_W-1:0] s;
    logic [WORD_W-1:0] candidate, candidate_nxt;
    logic [CNT_W-1:0]  count, count_nxt;
    logic [WORD_W-1:0] data_nxt;
    logic              new_data_nxt, overrun_nxt;
    logic              update;

    sync_chain #(
        .WIDTH (WORD_W),
        .DEPTH (SYNC_STAGES)
    ) u_sync (
        .clock   (clock),
        .n_reset (n_reset),
        .d       (sw),
        .q       (s)
    );

    always_ff @(posedge clock) begin
        if (!n_reset) begin
            state     <= STABLE;
            candidate <= '0;
            count     <= '0;
            data      <= '0;
            new_data  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_nxt;
            candidate <= candidate_nxt;
            count     <= count_nxt;
            data      <= data_nxt;
            new_data  <= new_data_nxt;
            overrun   <= overrun_nxt;
        end
    end

    // Any change of the synchronised value (re)opens the settle window.
    always_comb begin
        state_nxt     = state;
        candidate_nxt = candidate;
        count_nxt     = count;
        data_nxt      = data;
        update        = 1'b0;
        case (state)
            STABLE: begin
                if (s != candidate) begin
                    candidate_nxt = s;
                    count_nxt     = '0;
                    state_nxt     = SETTLING;
                end
            end
            SETTLING: begin
                if (s != candidate) begin
                    candidate_nxt = s;
                    count_nxt     = '0;
                end else if (count == COUNT_MAX) begin
                    state_nxt = STABLE;
                    if (candidate != data) begin
                        data_nxt = candidate;
                        update   = 1'b1;
                    end
                end else begin
                    count_nxt = count + CNT_W'(1);
                end
            end
            default: state_nxt = STABLE;
        endcase

        // A fresh update outranks a same-cycle read acknowledge.
        new_data_nxt = update | (new_data & ~rd);
        overrun_nxt  = (update & new_data) | (overrun & ~rd);
    end

endmodule
